// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter: op code width, flag-related
// op codes and the pipeline tag carried alongside each operation.
package alu_arb_pkg;

    localparam int OP_W = 4;

    // Only this op produces a meaningful zero flag.
    localparam logic [OP_W-1:0] ZERO_OP = 4'd4;

    // Ops at or below this code produce architected flags.
    localparam logic [OP_W-1:0] FLAG_OP_MAX = 4'd5;

    // Requester id width, wide enough for up to 8 requesters.
    localparam int ID_W = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [OP_W-1:0] op;
    } tag_t;

    // True when an op's flags should be written into the condition flags.
    function automatic logic updates_cc(input logic [OP_W-1:0] op);
        return (op <= FLAG_OP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: grants the first requester at or above the pointer,
// wrapping around to index 0 when nothing at or above the pointer is asking.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    // First pass covers ptr..NREQ-1, second pass wraps over 0..ptr-1.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (PW'(i) >= ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters. A round-robin
// grant loads the winner's op into a stage-1 register feeding the ALU; stage 2
// captures the ALU result and pulses the response back to the owner.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_op,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic [OP_W-1:0]      alu_select,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    input  logic [N-1:0]         alu_result,
    input  logic [1:0]           alu_flags,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [N-1:0]         rsp_result,
    output logic [1:0]           rsp_flags,
    output logic [NREQ*2-1:0]    cc_flags
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gnt_id;
    logic [OP_W-1:0] gnt_op;
    logic [N-1:0]    gnt_a;
    logic [N-1:0]    gnt_b;
    logic            gnt_any;
    tag_t            s1_tag;
    logic            s2_valid;
    logic [ID_W-1:0] s2_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Nothing is acknowledged while reset is held, since the pipeline would drop it.
    assign req_ready = rst_n ? grant : '0;
    assign gnt_any   = |req_ready;

    // Encode the one-hot grant into an index and steer the winner's op and operands.
    always_comb begin
        gnt_id = '0;
        gnt_op = '0;
        gnt_a  = '0;
        gnt_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_id = PW'(i);
                gnt_op = req_op[i*OP_W +: OP_W];
                gnt_a  = req_a[i*N +: N];
                gnt_b  = req_b[i*N +: N];
            end
        end
    end

    // Pointer moves just past the last winner, wrapping to 0; holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            if (gnt_id == PW'(NREQ - 1)) ptr <= '0;
            else                         ptr <= gnt_id + 1'b1;
        end
    end

    // Stage 1: latch the granted op into the ALU drive registers and tag it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tag     <= '0;
            alu_select <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else if (gnt_any) begin
            s1_tag.valid <= 1'b1;
            s1_tag.id    <= ID_W'(gnt_id);
            s1_tag.op    <= gnt_op;
            alu_select   <= gnt_op;
            alu_a        <= gnt_a;
            alu_b        <= gnt_b;
        end else begin
            s1_tag.valid <= 1'b0;
        end
    end

    // Stage 2: capture the ALU result and flags for the requester that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_id      <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (s1_tag.valid) begin
            s2_valid   <= 1'b1;
            s2_id      <= s1_tag.id;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
        end else begin
            s2_valid   <= 1'b0;
        end
    end

    // Condition flags update on the same edge the response appears, flag-producing ops only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_flags <= '0;
        end else if (s1_tag.valid && updates_cc(s1_tag.op)) begin
            for (int i = 0; i < NREQ; i++) begin
                if (s1_tag.id == ID_W'(i)) cc_flags[2*i +: 2] <= alu_flags;
            end
        end
    end

    // Decode the stage-2 owner into a one-cycle response pulse.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (s2_valid && (s2_id == ID_W'(i))) rsp_valid[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: acts as the shared ALU, drives directed and
// random requester traffic, and compares every cycle against a queue-based
// model of round-robin arbitration and two-cycle response delivery.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int N    = 4;
    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_op;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic [OP_W-1:0]      alu_select;
    logic [N-1:0]         alu_a;
    logic [N-1:0]         alu_b;
    logic [N-1:0]         alu_result;
    logic [1:0]           alu_flags;
    logic [NREQ-1:0]      rsp_valid;
    logic [N-1:0]         rsp_result;
    logic [1:0]           rsp_flags;
    logic [NREQ*2-1:0]    cc_flags;

    typedef struct {
        int              due;
        int              id;
        logic [N-1:0]    res;
        logic [1:0]      flg;
        logic [OP_W-1:0] op;
    } rsp_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int p_model  = 0;
    int base;

    rsp_t            rspq[$];
    logic [1:0]      cc_model[NREQ];
    logic            r_valid[NREQ];
    logic [OP_W-1:0] r_op[NREQ];
    logic [N-1:0]    r_a[NREQ];
    logic [N-1:0]    r_b[NREQ];
    logic [NREQ-1:0] last_grant;
    logic [NREQ-1:0] g_hist[$];
    logic [NREQ-1:0] rv_hist[$];
    logic [N-1:0]    smp_res;
    logic [1:0]      smp_flg;
    logic [NREQ*2-1:0] smp_cc;

    alu_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .cc_flags   (cc_flags)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {flags, result}; flags for ops above 5 are deliberately 00.
    function automatic logic [N+1:0] aluModel(input logic [OP_W-1:0] op,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic [N-1:0] res;
        logic [1:0]   f;
        case (op)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = a - b;
            4'd5:    res = a ^ b;
            4'd6:    res = a << 1;
            4'd7:    res = ~a;
            default: res = a;
        endcase
        f[0] = (op == ZERO_OP) && (res == '0);
        f[1] = (op <= FLAG_OP_MAX) ? res[N-1] : 1'b0;
        return {f, res};
    endfunction

    // The bench plays the shared combinational ALU.
    always_comb begin
        {alu_flags, alu_result} = aluModel(alu_select, alu_a, alu_b);
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refreshReq(input int i);
        r_op[i] = OP_W'($urandom_range(0, 9));
        r_a[i]  = N'($urandom);
        r_b[i]  = N'($urandom);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]             = r_valid[i];
            req_op[i*OP_W +: OP_W]   = r_op[i];
            req_a[i*N +: N]          = r_a[i];
            req_b[i*N +: N]          = r_b[i];
        end
    endtask

    // Per-cycle comparison against the model, then commit this cycle's grant to it.
    task automatic checkOutput();
        logic [NREQ-1:0]   eg;
        logic [NREQ-1:0]   erv;
        logic [N-1:0]      eres;
        logic [1:0]        eflg;
        logic [NREQ*2-1:0] ecc;
        logic [N+1:0]      fr;
        rsp_t              r;
        int                gi;
        eg = '0; erv = '0; eres = '0; eflg = '0; ecc = '0; gi = 0;
        if (!rst_n) begin
            rspq.delete();
            p_model = 0;
            for (int i = 0; i < NREQ; i++) cc_model[i] = 2'b00;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                gi = (p_model + k) % NREQ;
                if (eg == '0 && r_valid[gi]) eg[gi] = 1'b1;
            end
            if (rspq.size() > 0 && rspq[0].due == cyc) begin
                r = rspq.pop_front();
                erv[r.id] = 1'b1;
                eres = r.res;
                eflg = r.flg;
                if (r.op <= FLAG_OP_MAX) cc_model[r.id] = r.flg;
            end
        end
        for (int i = 0; i < NREQ; i++) ecc[2*i +: 2] = cc_model[i];

        checkVal("req_ready", 32'(req_ready), 32'(eg));
        checkVal("rsp_valid", 32'(rsp_valid), 32'(erv));
        checkVal("cc_flags", 32'(cc_flags), 32'(ecc));
        if (erv != '0) begin
            checkVal("rsp_result", 32'(rsp_result), 32'(eres));
            checkVal("rsp_flags", 32'(rsp_flags), 32'(eflg));
        end
        if (!rst_n) begin
            checkVal("rst_rsp_result", 32'(rsp_result), 32'd0);
            checkVal("rst_rsp_flags", 32'(rsp_flags), 32'd0);
            checkVal("rst_alu_select", 32'(alu_select), 32'd0);
            checkVal("rst_alu_a", 32'(alu_a), 32'd0);
            checkVal("rst_alu_b", 32'(alu_b), 32'd0);
        end

        g_hist.push_back(req_ready);
        rv_hist.push_back(rsp_valid);
        smp_res = rsp_result;
        smp_flg = rsp_flags;
        smp_cc  = cc_flags;

        if (eg != '0) begin
            for (int i = 0; i < NREQ; i++) if (eg[i]) gi = i;
            fr    = aluModel(r_op[gi], r_a[gi], r_b[gi]);
            r.due = cyc + 2;
            r.id  = gi;
            r.res = fr[N-1:0];
            r.flg = fr[N+1:N];
            r.op  = r_op[gi];
            rspq.push_back(r);
            p_model = (gi + 1) % NREQ;
        end
        last_grant = eg;
    endtask

    task automatic stepCycle();
        applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NREQ; i++) if (last_grant[i]) refreshReq(i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
        for (int k = 0; k < n; k++) stepCycle();
    endtask

    initial begin
        last_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            refreshReq(i);
            r_valid[i]  = 1'b1;
            cc_model[i] = 2'b00;
        end

        // Reset held with every requester asking.
        stepCycle();
        stepCycle();
        checkVal("rst_req_ready", 32'(req_ready), 32'd0);
        checkVal("rst_cc_flags", 32'(cc_flags), 32'd0);
        rst_n = 1'b1;
        stepCycle();
        checkVal("first_grant", 32'(g_hist[g_hist.size()-1]), 32'h1);
        idle(3);

        // Requester 0: op 4 with equal operands gives zero result and zero flag.
        r_valid[0] = 1'b1; r_op[0] = 4'd4; r_a[0] = 4'd3; r_b[0] = 4'd3;
        stepCycle();
        idle(1);
        checkVal("lat_no_early_rsp", 32'(rv_hist[rv_hist.size()-1]), 32'd0);
        stepCycle();
        checkVal("op4_rsp_valid", 32'(rv_hist[rv_hist.size()-1]), 32'h1);
        checkVal("op4_result", 32'(smp_res), 32'd0);
        checkVal("op4_flags", 32'(smp_flg), 32'h1);
        checkVal("op4_cc0", 32'(smp_cc[1:0]), 32'h1);
        idle(1);

        // Requester 1: set cc to 10, then op 6 must leave it untouched.
        r_valid[1] = 1'b1; r_op[1] = 4'd1; r_a[1] = 4'd1; r_b[1] = 4'd2;
        stepCycle();
        idle(2);
        checkVal("sub_cc1", 32'(smp_cc[3:2]), 32'h2);
        r_valid[1] = 1'b1; r_op[1] = 4'd6; r_a[1] = 4'd5; r_b[1] = 4'd0;
        stepCycle();
        idle(2);
        checkVal("op6_rsp_valid", 32'(rv_hist[rv_hist.size()-1]), 32'h2);
        checkVal("op6_result", 32'(smp_res), 32'hA);
        checkVal("op6_cc1_hold", 32'(smp_cc[3:2]), 32'h2);
        idle(1);

        // Both requesters for six cycles: strict alternation starting at 0.
        base = g_hist.size();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b1;
            stepCycle();
        end
        idle(3);
        for (int k = 0; k < 6; k++) begin
            checkVal($sformatf("alt_grant%0d", k), 32'(g_hist[base+k]), (k % 2 == 0) ? 32'h1 : 32'h2);
            checkVal($sformatf("alt_rsp%0d", k), 32'(rv_hist[base+k+2]), (k % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Requester 1 alone for three cycles, then both.
        base = g_hist.size();
        for (int k = 0; k < 5; k++) begin
            r_valid[0] = (k >= 3);
            r_valid[1] = 1'b1;
            stepCycle();
        end
        idle(3);
        checkVal("solo_g0", 32'(g_hist[base]),   32'h2);
        checkVal("solo_g1", 32'(g_hist[base+1]), 32'h2);
        checkVal("solo_g2", 32'(g_hist[base+2]), 32'h2);
        checkVal("solo_g3", 32'(g_hist[base+3]), 32'h1);
        checkVal("solo_g4", 32'(g_hist[base+4]), 32'h2);

        // Reset pulsed one cycle after a transfer discards the in-flight op.
        r_valid[0] = 1'b1; r_op[0] = 4'd0; r_a[0] = 4'd2; r_b[0] = 4'd3;
        stepCycle();
        for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        base = rv_hist.size();
        idle(4);
        for (int k = 0; k < 4; k++)
            checkVal($sformatf("flush_rsp%0d", k), 32'(rv_hist[base+k]), 32'd0);
        checkVal("flush_result", 32'(rsp_result), 32'd0);
        checkVal("flush_flags", 32'(rsp_flags), 32'd0);
        checkVal("flush_cc", 32'(cc_flags), 32'd0);
        checkVal("flush_alu_sel", 32'(alu_select), 32'd0);
        checkVal("flush_alu_a", 32'(alu_a), 32'd0);
        checkVal("flush_alu_b", 32'(alu_b), 32'd0);
        checkVal("flush_ready", 32'(req_ready), 32'd0);

        // Random traffic; a requester only changes its request after being granted.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r_valid[i] || last_grant[i]) begin
                    r_valid[i] = ($urandom_range(0, 3) != 0);
                    if (!r_valid[i]) refreshReq(i);
                end
            end
            stepCycle();
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
